// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Sticky overrun/frame error flags, cleared by clr_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 12;
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    logic          sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0]    vld_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          frame_set;
    logic          fall;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d, frame_q, frame_d;
    logic          empty, full, pop, wr, ovf_set;

    // A falling edge only counts once a real high has been seen after reset.
    assign fall = armed_q & prev_q & ~sync2_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & sync2_q);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = HALF_LD;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        cnt_d   = FULL_LD;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (sync2_q) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BREAK: begin
                if (sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // shift_q is stable during the push cycle (FSM sits in IDLE/START).
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH);
    assign pop     = rd_en & ~empty;
    assign wr      = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    always_comb begin
        wptr_d  = wr  ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        unique case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overrun_d = overrun_q;
        if (ovf_set)      overrun_d = 1'b1;
        else if (clr_err) overrun_d = 1'b0;
        frame_d = frame_q;
        if (frame_set)    frame_d = 1'b1;
        else if (clr_err) frame_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr) mem[wptr_q] <= shift_q;
    end

    assign rd_data    = empty ? 8'h00 : mem[rptr_q];
    assign rx_valid   = ~empty;
    assign fifo_full  = full;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_q;

endmodule
